// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (imem)
// and data memory (dmem). Each side has a one-entry pending slot. Requests are
// granted one at a time, and the response is routed back to the owner.
// Optional feature macro: MEM_ARB_RR_EN selects strict round-robin
// arbitration. Without it, dmem has priority, limited by a starvation counter.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t      state_q, state_d;
  logic        i_valid_q, i_valid_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic [3:0]  i_rmask_q, i_rmask_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [3:0]  d_rmask_q, d_rmask_d;
  logic [3:0]  d_wmask_q, d_wmask_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_rmask_q, mem_rmask_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef MEM_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`else
  logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

  logic        i_pulse, d_pulse, i_accept, d_accept, i_avail, d_avail, pick_d;
  logic [3:0]  d_in_rmask;
  logic [31:0] i_req_addr, d_req_addr, d_req_wdata;
  logic [3:0]  i_req_rmask, d_req_rmask, d_req_wmask;

  // A pulse is dropped while its slot is full or its transaction is still
  // outstanding. The response cycle counts as free, so the owner can chain.
  assign i_pulse    = |imem_rmask;
  assign d_pulse    = (|dmem_rmask) | (|dmem_wmask);
  assign i_accept   = i_pulse && !i_valid_q && !((state_q == WAIT_I) && !mem_resp);
  assign d_accept   = d_pulse && !d_valid_q && !((state_q == WAIT_D) && !mem_resp);
  assign i_avail    = i_valid_q | i_accept;
  assign d_avail    = d_valid_q | d_accept;
  assign d_in_rmask = (|dmem_wmask) ? 4'h0 : dmem_rmask;

  // A request arriving while idle bypasses its slot, which gives one-cycle latency.
  assign i_req_addr  = i_valid_q ? i_addr_q : imem_addr;
  assign i_req_rmask = i_valid_q ? i_rmask_q : imem_rmask;
  assign d_req_addr  = d_valid_q ? d_addr_q : dmem_addr;
  assign d_req_rmask = d_valid_q ? d_rmask_q : d_in_rmask;
  assign d_req_wmask = d_valid_q ? d_wmask_q : dmem_wmask;
  assign d_req_wdata = d_valid_q ? d_wdata_q : dmem_wdata;

`ifdef MEM_ARB_RR_EN
  assign pick_d = d_avail && (!i_avail || !last_grant_q);
`else
  assign pick_d = d_avail && (!i_avail || (starve_cnt_q != 4'(STARVE_LIMIT)));
`endif

  // Next-state logic: capture slots, pick a winner from IDLE, and wait for the response.
  always_comb begin
    state_d     = state_q;
    i_valid_d   = i_valid_q;
    i_addr_d    = i_addr_q;
    i_rmask_d   = i_rmask_q;
    d_valid_d   = d_valid_q;
    d_addr_d    = d_addr_q;
    d_rmask_d   = d_rmask_q;
    d_wmask_d   = d_wmask_q;
    d_wdata_d   = d_wdata_q;
    mem_addr_d  = 32'h0;
    mem_rmask_d = 4'h0;
    mem_wmask_d = 4'h0;
    mem_wdata_d = 32'h0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    if (i_accept) begin
      i_valid_d = 1'b1;
      i_addr_d  = imem_addr;
      i_rmask_d = imem_rmask;
    end
    if (d_accept) begin
      d_valid_d = 1'b1;
      d_addr_d  = dmem_addr;
      d_rmask_d = d_in_rmask;
      d_wmask_d = dmem_wmask;
      d_wdata_d = dmem_wdata;
    end
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          mem_addr_d  = d_req_addr & 32'hFFFF_FFFC;
          mem_rmask_d = d_req_rmask;
          mem_wmask_d = d_req_wmask;
          mem_wdata_d = (|d_req_wmask) ? d_req_wdata : 32'h0;
          d_valid_d   = 1'b0;
          state_d     = WAIT_D;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b1;
`else
          if (i_avail && (starve_cnt_q != 4'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + 4'd1;
`endif
        end else if (i_avail) begin
          mem_addr_d  = i_req_addr & 32'hFFFF_FFFC;
          mem_rmask_d = i_req_rmask;
          i_valid_d   = 1'b0;
          state_d     = WAIT_I;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b0;
`else
          starve_cnt_d = 4'd0;
`endif
        end
      end
      WAIT_I, WAIT_D: begin
        if (mem_resp)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and slot registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_valid_q   <= 1'b0;
      i_addr_q    <= 32'h0;
      i_rmask_q   <= 4'h0;
      d_valid_q   <= 1'b0;
      d_addr_q    <= 32'h0;
      d_rmask_q   <= 4'h0;
      d_wmask_q   <= 4'h0;
      d_wdata_q   <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_rmask_q <= 4'h0;
      mem_wmask_q <= 4'h0;
      mem_wdata_q <= 32'h0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      i_valid_q   <= i_valid_d;
      i_addr_q    <= i_addr_d;
      i_rmask_q   <= i_rmask_d;
      d_valid_q   <= d_valid_d;
      d_addr_q    <= d_addr_d;
      d_rmask_q   <= d_rmask_d;
      d_wmask_q   <= d_wmask_d;
      d_wdata_q   <= d_wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

  // The response goes to the owner only in the matching wait state. A response in IDLE is ignored.
  assign imem_resp  = (state_q == WAIT_I) && mem_resp;
  assign dmem_resp  = (state_q == WAIT_D) && mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

endmodule
